cc_coef_csr: RTL and testbench

CC_COEF_CSR -- requirements
Module: cc_coef_csr

---
 rtl/cc_coef_csr_pkg.sv | 36 +++
 rtl/cc_coef_csr_if.sv | 33 +++
 rtl/cc_coef_csr_axil_wr_slot.sv | 32 +++
 rtl/cc_coef_csr.sv | 187 ++++++++++++++++++
 tb/tb_cc_coef_csr.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cc_coef_csr_pkg.sv
// Shared constants, payload types and helpers for the colour-correction coefficient CSR block.
package cc_coef_csr_pkg;

  localparam int unsigned AXIL_AW = 32;
  localparam int unsigned AXIL_DW = 32;
  localparam int unsigned AXIL_SW = AXIL_DW / 8;

  // Word offsets from BASE_ADDR
  localparam int unsigned CC_CTRL_CR     = 0;
  localparam int unsigned CC_STATUS_SR   = 1;
  localparam int unsigned CC_SHADOW_BASE = 4;

  localparam int unsigned CTRL_COMMIT_BIT = 0;
  localparam int unsigned CTRL_AUTO_BIT   = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXIL_DW-1:0] data;
    logic [AXIL_SW-1:0] strb;
  } axil_w_t;

  // Byte-lane merge of new write data over the current register value
  function automatic logic [AXIL_DW-1:0] apply_strb(input logic [AXIL_DW-1:0] old_v,
                                                    input logic [AXIL_DW-1:0] new_v,
                                                    input logic [AXIL_SW-1:0] strb);
    logic [AXIL_DW-1:0] res;
    res = old_v;
    for (int unsigned b = 0; b < AXIL_SW; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/cc_coef_csr_if.sv
// AXI4-Lite register bus with master/slave views.
interface axi4_lite_if;
  import cc_coef_csr_pkg::*;

  logic [AXIL_AW-1:0] awaddr;
  logic               awvalid;
  logic               awready;
  logic [AXIL_DW-1:0] wdata;
  logic [AXIL_SW-1:0] wstrb;
  logic               wvalid;
  logic               wready;
  logic [1:0]         bresp;
  logic               bvalid;
  logic               bready;
  logic [AXIL_AW-1:0] araddr;
  logic               arvalid;
  logic               arready;
  logic [AXIL_DW-1:0] rdata;
  logic [1:0]         rresp;
  logic               rvalid;
  logic               rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/cc_coef_csr_axil_wr_slot.sv
// One-entry valid/data holding slot; ready upstream is simply !full_o.
module axil_wr_slot #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  input  logic         clr_i,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  logic         r_full;
  logic [W-1:0] r_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (clr_i) begin
      r_full <= 1'b0;
    end else if (in_valid_i && !r_full) begin
      r_full <= 1'b1;
      r_data <= in_data_i;
    end
  end

  assign full_o = r_full;
  assign data_o = r_data;

endmodule

// File: rtl/cc_coef_csr.sv
// Coefficient CSR: AXI4-Lite shadow registers copied to the active set on start-of-frame.
module cc_coef_csr
  import cc_coef_csr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned COEF_CNT  = 12,
  parameter int unsigned COEF_W    = 18
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  axi4_lite_if.slave                      csr_i,
  input  logic                            sof_i,
  output logic [COEF_CNT-1:0][COEF_W-1:0] coef_o,
  output logic                            pending_o
);

  localparam int unsigned NREG      = CC_SHADOW_BASE + COEF_CNT;
  localparam int unsigned IDX_W     = 7;
  localparam logic [31:0] MAP_BYTES = 32'(NREG * 4);

  logic [COEF_CNT-1:0][COEF_W-1:0] r_shadow;
  logic [COEF_CNT-1:0][COEF_W-1:0] r_active;
  logic                            r_auto;
  logic                            r_pending;
  logic [7:0]                      r_commit_cnt;
  logic                            r_bvalid;
  logic [1:0]                      r_bresp;
  logic                            r_rvalid;
  logic [AXIL_DW-1:0]              r_rdata;
  logic [1:0]                      r_rresp;

  logic                            w_aw_full;
  logic                            w_w_full;
  logic [AXIL_AW-1:0]              w_aw_addr;
  axil_w_t                         w_w_slot;
  logic                            w_exec;
  logic                            w_copy;
  logic [31:0]                     w_wr_off;
  logic [31:0]                     w_rd_off;
  logic                            w_wr_hit;
  logic                            w_rd_hit;
  logic [IDX_W-1:0]                w_wr_idx;
  logic [IDX_W-1:0]                w_rd_idx;
  logic                            w_wr_ctrl;
  logic                            w_wr_ok;
  logic                            w_commit_wr;
  logic [COEF_CNT-1:0]             w_sh_we;
  logic [COEF_CNT-1:0][COEF_W-1:0] w_sh_nxt;
  logic [AXIL_DW-1:0]              w_rd_data;
  logic                            w_rd_err;

  axil_wr_slot #(.W(AXIL_AW)) u_aw_slot (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (csr_i.awvalid),
    .in_data_i  (csr_i.awaddr),
    .clr_i      (w_exec),
    .full_o     (w_aw_full),
    .data_o     (w_aw_addr)
  );

  axil_wr_slot #(.W($bits(axil_w_t))) u_w_slot (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (csr_i.wvalid),
    .in_data_i  ({csr_i.wdata, csr_i.wstrb}),
    .clr_i      (w_exec),
    .full_o     (w_w_full),
    .data_o     (w_w_slot)
  );

  // A write executes once both halves are held and the previous B has been taken
  assign w_exec = w_aw_full && w_w_full && !r_bvalid;
  assign w_copy = sof_i && (r_pending || r_auto);

  assign w_wr_off    = w_aw_addr - BASE_ADDR;
  assign w_wr_hit    = w_wr_off < MAP_BYTES;
  assign w_wr_idx    = w_wr_off[IDX_W+1:2];
  assign w_wr_ctrl   = w_wr_hit && (w_wr_idx == IDX_W'(CC_CTRL_CR));
  assign w_wr_ok     = w_wr_ctrl || (w_wr_hit && (w_wr_idx >= IDX_W'(CC_SHADOW_BASE)));
  assign w_commit_wr = w_exec && w_wr_ctrl && w_w_slot.strb[0] && w_w_slot.data[CTRL_COMMIT_BIT];

  assign w_rd_off = csr_i.araddr - BASE_ADDR;
  assign w_rd_hit = w_rd_off < MAP_BYTES;
  assign w_rd_idx = w_rd_off[IDX_W+1:2];

  // Per-coefficient write enable and strobe-merged next value
  always_comb begin
    w_sh_we  = '0;
    w_sh_nxt = r_shadow;
    for (int unsigned i = 0; i < COEF_CNT; i++) begin
      w_sh_we[i]  = w_exec && w_wr_hit && (w_wr_idx == IDX_W'(CC_SHADOW_BASE + i));
      w_sh_nxt[i] = COEF_W'(apply_strb(32'(signed'(r_shadow[i])), w_w_slot.data, w_w_slot.strb));
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b1;
    if (w_rd_hit) begin
      if (w_rd_idx == IDX_W'(CC_CTRL_CR)) begin
        w_rd_data[CTRL_AUTO_BIT] = r_auto;
        w_rd_err                 = 1'b0;
      end else if (w_rd_idx == IDX_W'(CC_STATUS_SR)) begin
        w_rd_data = {16'h0000, r_commit_cnt, 7'h00, r_pending};
        w_rd_err  = 1'b0;
      end
      for (int unsigned i = 0; i < COEF_CNT; i++) begin
        if (w_rd_idx == IDX_W'(CC_SHADOW_BASE + i)) begin
          w_rd_data = 32'(signed'(r_shadow[i]));
          w_rd_err  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_shadow <= '0;
    end else begin
      for (int unsigned i = 0; i < COEF_CNT; i++) begin
        if (w_sh_we[i]) r_shadow[i] <= w_sh_nxt[i];
      end
    end
  end

  // Copy samples the shadow before any same-cycle write lands
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_active     <= '0;
      r_commit_cnt <= '0;
    end else if (w_copy) begin
      r_active     <= r_shadow;
      r_commit_cnt <= r_commit_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_auto    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      if (w_exec && w_wr_ctrl && w_w_slot.strb[0]) r_auto <= w_w_slot.data[CTRL_AUTO_BIT];
      if (w_commit_wr)  r_pending <= 1'b1;
      else if (w_copy)  r_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_exec) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (r_bvalid && csr_i.bready) begin
      r_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (csr_i.arvalid && !r_rvalid) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (r_rvalid && csr_i.rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign csr_i.awready = !w_aw_full;
  assign csr_i.wready  = !w_w_full;
  assign csr_i.bvalid  = r_bvalid;
  assign csr_i.bresp   = r_bresp;
  assign csr_i.arready = !r_rvalid;
  assign csr_i.rvalid  = r_rvalid;
  assign csr_i.rdata   = r_rdata;
  assign csr_i.rresp   = r_rresp;

  assign coef_o    = r_active;
  assign pending_o = r_pending;

endmodule

// File: tb/tb_cc_coef_csr.sv
// Directed self-checking bench for cc_coef_csr with hand-computed expectations.
module tb_cc_coef_csr;
  import cc_coef_csr_pkg::*;

  localparam int unsigned COEF_CNT = 12;
  localparam int unsigned COEF_W   = 18;
  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_STAT   = 32'h04;
  localparam logic [31:0] A_RSVD   = 32'h08;
  localparam logic [31:0] A_SH0    = 32'h10;
  localparam logic [31:0] A_SH1    = 32'h14;
  localparam logic [31:0] A_SH2    = 32'h18;
  localparam logic [31:0] A_SH3    = 32'h1C;
  localparam logic [31:0] A_SH4    = 32'h20;
  localparam logic [31:0] A_SH5    = 32'h24;
  localparam logic [31:0] A_UNMAP  = 32'(4 * (4 + COEF_CNT));

  logic clk_i = 1'b0;
  logic rst_i;
  logic sof_i;
  logic pending_o;
  logic [COEF_CNT-1:0][COEF_W-1:0] coef_o;

  int n_chk = 0;
  int n_err = 0;

  logic [1:0]  resp;
  logic [31:0] rd;

  axi4_lite_if csr ();

  cc_coef_csr #(.BASE_ADDR(32'h0), .COEF_CNT(COEF_CNT), .COEF_W(COEF_W)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .csr_i     (csr),
    .sof_i     (sof_i),
    .coef_o    (coef_o),
    .pending_o (pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly);
    int   n;
    logic aw_done, w_done, aw_hs, w_hs;
    @(posedge clk_i); #1;
    csr.awaddr  = a;
    csr.wdata   = d;
    csr.wstrb   = s;
    csr.wvalid  = 1'b1;
    csr.awvalid = (aw_dly == 0);
    aw_done = 1'b0;
    w_done  = 1'b0;
    n       = 0;
    while (!(aw_done && w_done) && n < 100) begin
      aw_hs = csr.awvalid && csr.awready;
      w_hs  = csr.wvalid && csr.wready;
      @(posedge clk_i); #1;
      n++;
      if (aw_hs) begin csr.awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin csr.wvalid  = 1'b0; w_done  = 1'b1; end
      if (!aw_done && !csr.awvalid && n >= aw_dly) csr.awvalid = 1'b1;
    end
    csr.awvalid = 1'b0;
    csr.wvalid  = 1'b0;
    chk("aw_w_accept", 32'({aw_done, w_done}), 32'h3);
  endtask

  task automatic wait_b(output logic [1:0] r);
    int n;
    n = 0;
    while (!csr.bvalid && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("bvalid", 32'(csr.bvalid), 32'h1);
    r = csr.bresp;
    if (csr.bready) begin
      @(posedge clk_i); #1;
    end
  endtask

  task automatic axil_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int aw_dly, output logic [1:0] r);
    send_aw_w(a, d, s, aw_dly);
    wait_b(r);
  endtask

  task automatic axil_rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    int   n;
    logic hs;
    @(posedge clk_i); #1;
    csr.araddr  = a;
    csr.arvalid = 1'b1;
    n  = 0;
    hs = 1'b0;
    while (!hs && n < 50) begin
      hs = csr.arready;
      @(posedge clk_i); #1;
      n++;
    end
    csr.arvalid = 1'b0;
    chk("rvalid_lat1", 32'(csr.rvalid), 32'h1);
    d = csr.rdata;
    r = csr.rresp;
    @(posedge clk_i); #1;
  endtask

  // Full write whose execution cycle coincides with an sof_i pulse
  task automatic wr_sof(input logic [31:0] a, input logic [31:0] d, output logic [1:0] r);
    @(posedge clk_i); #1;
    csr.awaddr  = a;
    csr.wdata   = d;
    csr.wstrb   = 4'hF;
    csr.awvalid = 1'b1;
    csr.wvalid  = 1'b1;
    @(posedge clk_i); #1;
    csr.awvalid = 1'b0;
    csr.wvalid  = 1'b0;
    sof_i       = 1'b1;
    @(posedge clk_i); #1;
    sof_i = 1'b0;
    chk("sof_wr_bvalid", 32'(csr.bvalid), 32'h1);
    r = csr.bresp;
    @(posedge clk_i); #1;
  endtask

  task automatic pulse_sof();
    @(posedge clk_i); #1;
    sof_i = 1'b1;
    @(posedge clk_i); #1;
    sof_i = 1'b0;
  endtask

  initial begin
    rst_i       = 1'b1;
    sof_i       = 1'b0;
    csr.awvalid = 1'b0;
    csr.awaddr  = '0;
    csr.wvalid  = 1'b0;
    csr.wdata   = '0;
    csr.wstrb   = '0;
    csr.bready  = 1'b1;
    csr.arvalid = 1'b0;
    csr.araddr  = '0;
    csr.rready  = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    chk("rst_awready", 32'(csr.awready), 32'h1);
    chk("rst_wready",  32'(csr.wready),  32'h1);
    chk("rst_arready", 32'(csr.arready), 32'h1);
    chk("rst_bvalid",  32'(csr.bvalid),  32'h0);
    chk("rst_rvalid",  32'(csr.rvalid),  32'h0);
    chk("rst_pending", 32'(pending_o),   32'h0);

    // W first, AW three cycles later; 18-bit all-ones reads back as -1
    axil_wr(A_SH0, 32'h0003_FFFF, 4'hF, 3, resp);
    chk("sh0_bresp", 32'(resp), 32'(RESP_OKAY));
    axil_rd(A_SH0, rd, resp);
    chk("sh0_rdata", rd, 32'hFFFF_FFFF);
    chk("sh0_rresp", 32'(resp), 32'(RESP_OKAY));
    chk("sh0_active_unchanged", 32'(coef_o[0]), 32'h0);

    // Commit then sof
    axil_wr(A_SH2, 32'h0000_0100, 4'hF, 0, resp);
    axil_wr(A_CTRL, 32'h1, 4'hF, 0, resp);
    chk("commit_pending", 32'(pending_o), 32'h1);
    axil_rd(A_CTRL, rd, resp);
    chk("ctrl_commit_reads0", rd, 32'h0);
    pulse_sof();
    chk("commit_coef2", 32'(coef_o[2]), 32'h100);
    chk("commit_pending_clr", 32'(pending_o), 32'h0);
    axil_rd(A_STAT, rd, resp);
    chk("status_cnt1", rd, 32'h0000_0100);

    // Error accesses
    axil_wr(A_RSVD, 32'hFFFF_FFFF, 4'hF, 0, resp);
    chk("rsvd_wr_slverr", 32'(resp), 32'(RESP_SLVERR));
    axil_wr(A_STAT, 32'hFFFF_FFFF, 4'hF, 0, resp);
    chk("stat_wr_slverr", 32'(resp), 32'(RESP_SLVERR));
    axil_rd(A_UNMAP, rd, resp);
    chk("unmap_rd_slverr", 32'(resp), 32'(RESP_SLVERR));
    chk("unmap_rd_zero", rd, 32'h0);
    axil_rd(A_STAT, rd, resp);
    chk("status_after_err", rd, 32'h0000_0100);
    chk("pending_after_err", 32'(pending_o), 32'h0);

    // Byte strobe: only lane 1 replaced
    axil_wr(A_SH2, 32'h00AA_BBCC, 4'b0010, 0, resp);
    axil_rd(A_SH2, rd, resp);
    chk("strb_lane1", rd, 32'h0000_BB00);
    chk("strb_active_kept", 32'(coef_o[2]), 32'h100);

    // Back-pressure on B blocks the next write
    csr.bready = 1'b0;
    axil_wr(A_SH3, 32'h7, 4'hF, 0, resp);
    send_aw_w(A_SH3, 32'h9, 4'hF, 0);
    repeat (10) @(posedge clk_i);
    #1;
    chk("bp_awready", 32'(csr.awready), 32'h0);
    chk("bp_wready",  32'(csr.wready),  32'h0);
    chk("bp_bvalid",  32'(csr.bvalid),  32'h1);
    axil_rd(A_SH3, rd, resp);
    chk("bp_not_executed", rd, 32'h7);
    csr.bready = 1'b1;
    @(posedge clk_i); #1;
    chk("bp_b1_done", 32'(csr.bvalid), 32'h0);
    wait_b(resp);
    chk("bp_b2_resp", 32'(resp), 32'(RESP_OKAY));
    axil_rd(A_SH3, rd, resp);
    chk("bp_second_exec", rd, 32'h9);

    // AUTO mode; shadow write in the copy cycle goes in on the next sof
    axil_wr(A_CTRL, 32'h2, 4'hF, 0, resp);
    wr_sof(A_SH1, 32'h5, resp);
    chk("auto_coef1_first", 32'(coef_o[1]), 32'h0);
    pulse_sof();
    chk("auto_coef1_second", 32'(coef_o[1]), 32'h5);
    axil_rd(A_STAT, rd, resp);
    chk("status_cnt3", rd, 32'h0000_0300);
    axil_rd(A_CTRL, rd, resp);
    chk("ctrl_auto_rd", rd, 32'h2);

    // COMMIT coinciding with sof while idle: deferred to the next sof
    axil_wr(A_CTRL, 32'h0, 4'hF, 0, resp);
    axil_wr(A_SH4, 32'h22, 4'hF, 0, resp);
    pulse_sof();
    chk("idle_sof_no_copy", 32'(coef_o[4]), 32'h0);
    wr_sof(A_CTRL, 32'h1, resp);
    chk("defer_pending", 32'(pending_o), 32'h1);
    chk("defer_no_copy", 32'(coef_o[4]), 32'h0);
    axil_wr(A_CTRL, 32'h1, 4'hF, 0, resp);
    chk("commit_idem", 32'(pending_o), 32'h1);
    pulse_sof();
    chk("defer_copy", 32'(coef_o[4]), 32'h22);
    axil_rd(A_STAT, rd, resp);
    chk("status_cnt4", rd, 32'h0000_0400);

    // Drive commit_cnt through 255 and around to 0
    for (int k = 0; k < 252; k++) begin
      axil_wr(A_CTRL, 32'h1, 4'hF, 0, resp);
      pulse_sof();
      if (k == 250) begin
        axil_rd(A_STAT, rd, resp);
        chk("status_cnt255", rd, 32'h0000_FF00);
      end
    end
    axil_rd(A_STAT, rd, resp);
    chk("status_wrap0", rd, 32'h0000_0000);

    // Reset with both slots loaded: no B may appear afterwards
    @(posedge clk_i); #1;
    csr.awaddr  = A_SH5;
    csr.wdata   = 32'h55;
    csr.wstrb   = 4'hF;
    csr.awvalid = 1'b1;
    csr.wvalid  = 1'b1;
    @(posedge clk_i); #1;
    csr.awvalid = 1'b0;
    csr.wvalid  = 1'b0;
    rst_i       = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_txn_bvalid",  32'(csr.bvalid),  32'h0);
    chk("rst_txn_awready", 32'(csr.awready), 32'h1);
    chk("rst_txn_coef2",   32'(coef_o[2]),   32'h0);
    axil_rd(A_SH5, rd, resp);
    chk("rst_txn_sh5", rd, 32'h0);
    axil_rd(A_SH0, rd, resp);
    chk("rst_sh0_clr", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
